doodle_motion: RTL

Upstream kinematics stage for doodle_sm. It generates the game move tick and integrates the doodle's position and speed every tick, driven by the state-machine one-hot state, is_in_middle and the player buttons. It produces object_x, object_y, up_count, vert_speed and true_y, which doodle_sm consumes for jump-height, scroll and landing decisions.

---
 rtl/doodle_motion.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/doodle_motion.sv
// Doodle kinematics: move-tick generator plus per-tick integration of x/y position,
// world height, rise distance and vertical speed, driven by the doodle_sm one-hot state.
module doodle_motion #(
  parameter int TICK_DIV    = 1666667,
  parameter int X_START     = 459,
  parameter int Y_START     = 400,
  parameter int X_MIN       = 157,
  parameter int X_MAX       = 761,
  parameter int H_STEP      = 3,
  parameter int Y_TOP       = 48,
  parameter int Y_BOTTOM    = 540,
  parameter int MAX_SPEED   = 8,
  parameter int MIN_SPEED   = 1,
  parameter int ACCEL_TICKS = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        q_I,
  input  logic        q_Up,
  input  logic        q_Down,
  input  logic        q_Done,
  input  logic        is_in_middle,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        move_tick,
  output logic [15:0] object_x,
  output logic [15:0] object_y,
  output logic [9:0]  up_count,
  output logic [3:0]  vert_speed,
  output logic [15:0] true_y
);

  localparam logic [20:0] TICK_LAST = 21'(TICK_DIV - 1);
  localparam logic [15:0] XS        = 16'(X_START);
  localparam logic [15:0] YS        = 16'(Y_START);
  localparam logic [15:0] XMIN      = 16'(X_MIN);
  localparam logic [15:0] XMAX      = 16'(X_MAX);
  localparam logic [15:0] HSTEP     = 16'(H_STEP);
  localparam logic [15:0] YTOP      = 16'(Y_TOP);
  localparam logic [15:0] YBOT      = 16'(Y_BOTTOM);
  localparam logic [3:0]  SMAX      = 4'(MAX_SPEED);
  localparam logic [3:0]  SMIN      = 4'(MIN_SPEED);
  localparam logic [7:0]  ACC_LAST  = 8'(ACCEL_TICKS - 1);

  typedef enum logic [1:0] {PH_IDLE, PH_UP, PH_DOWN, PH_DONE} phase_e;

  logic [20:0] tick_cnt_q, tick_cnt_d;
  logic        move_tick_q, move_tick_d;
  logic [15:0] x_q, x_d, y_q, y_d, ty_q, ty_d;
  logic [9:0]  up_q, up_d;
  logic [3:0]  spd_q, spd_d;
  logic [7:0]  acc_q, acc_d;
  phase_e      phase_q, phase_d;

  phase_e      cur_phase;
  logic [3:0]  s;
  logic [15:0] s16;
  logic [7:0]  acc;
  logic [9:0]  up_base;
  logic [15:0] up_sum;
  logic [15:0] x_mv;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt_q  <= '0;
      move_tick_q <= 1'b0;
      x_q         <= XS;
      y_q         <= YS;
      ty_q        <= YS;
      up_q        <= '0;
      spd_q       <= SMAX;
      acc_q       <= '0;
      phase_q     <= PH_IDLE;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      move_tick_q <= move_tick_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ty_q        <= ty_d;
      up_q        <= up_d;
      spd_q       <= spd_d;
      acc_q       <= acc_d;
      phase_q     <= phase_d;
    end
  end

  // Anything other than exactly one state bit is treated as game-over (hold).
  always_comb begin
    case ({q_I, q_Up, q_Down, q_Done})
      4'b1000: cur_phase = PH_IDLE;
      4'b0100: cur_phase = PH_UP;
      4'b0010: cur_phase = PH_DOWN;
      default: cur_phase = PH_DONE;
    endcase
  end

  always_comb begin
    if (btn_right && !btn_left)
      x_mv = (x_q + HSTEP > XMAX) ? XMIN : x_q + HSTEP;
    else if (btn_left && !btn_right)
      x_mv = (x_q < XMIN + HSTEP) ? XMAX : x_q - HSTEP;
    else
      x_mv = x_q;
  end

  always_comb begin
    tick_cnt_d  = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 21'd1;
    move_tick_d = (tick_cnt_q == TICK_LAST);
    x_d         = x_q;
    y_d         = y_q;
    ty_d        = ty_q;
    up_d        = up_q;
    spd_d       = spd_q;
    acc_d       = acc_q;
    phase_d     = phase_q;
    s           = spd_q;
    acc         = acc_q;
    up_base     = up_q;
    s16         = '0;
    up_sum      = '0;

    if (move_tick_q) begin
      phase_d = cur_phase;
      case (cur_phase)
        PH_IDLE: begin
          x_d   = XS;
          y_d   = YS;
          ty_d  = YS;
          up_d  = '0;
          spd_d = SMAX;
          acc_d = '0;
        end
        PH_UP: begin
          // A fresh launch integrates with full speed on this very tick.
          if (phase_q != PH_UP) begin
            s       = SMAX;
            acc     = '0;
            up_base = '0;
          end
          s16    = {12'd0, s};
          up_sum = {6'd0, up_base} + s16;
          up_d   = (up_sum > 16'd1023) ? 10'd1023 : up_sum[9:0];
          ty_d   = ty_q - s16;
          if (!is_in_middle)
            y_d = (y_q < YTOP + s16) ? YTOP : y_q - s16;
          if (acc == ACC_LAST) begin
            spd_d = (s > SMIN) ? s - 4'd1 : SMIN;
            acc_d = '0;
          end else begin
            spd_d = s;
            acc_d = acc + 8'd1;
          end
          x_d = x_mv;
        end
        PH_DOWN: begin
          if (phase_q != PH_DOWN) begin
            s   = SMIN;
            acc = '0;
          end
          s16  = {12'd0, s};
          y_d  = (y_q + s16 > YBOT) ? YBOT : y_q + s16;
          ty_d = ty_q + s16;
          if (acc == ACC_LAST) begin
            spd_d = (s < SMAX) ? s + 4'd1 : SMAX;
            acc_d = '0;
          end else begin
            spd_d = s;
            acc_d = acc + 8'd1;
          end
          x_d = x_mv;
        end
        default: ;
      endcase
    end
  end

  assign move_tick  = move_tick_q;
  assign object_x   = x_q;
  assign object_y   = y_q;
  assign true_y     = ty_q;
  assign up_count   = up_q;
  assign vert_speed = spd_q;

endmodule
